// File: rtl/cond_predicate_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_predicate_unit
// Brief    : EXE-stage NZCV status register, condition evaluation and IT blocks
// Revision : 1.0  initial release
// ============================================================================
module cond_predicate_unit #(
    parameter  int            IT_DEPTH   = 4,
    parameter  logic [3:0]    STATUS_RST = 4'b0000,
    localparam int            CNT_W      = $clog2(IT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [3:0]          cond,
    input  logic                s_update,
    input  logic [3:0]          alu_status,
    input  logic                it_start,
    input  logic [3:0]          it_cond,
    input  logic [CNT_W-1:0]    it_len,
    input  logic [IT_DEPTH-1:0] it_mask,
    output logic                exec_en,
    output logic [3:0]          status_q,
    output logic                it_active,
    output logic [CNT_W-1:0]    it_remaining,
    output logic                it_err
);

    localparam logic [CNT_W-1:0] C_MAX_LEN = CNT_W'(IT_DEPTH);

    logic [3:0]          status_d;
    logic                it_active_q, it_active_d;
    logic [CNT_W-1:0]    it_remaining_q, it_remaining_d;
    logic                it_err_q, it_err_d;
    logic [3:0]          it_base_q, it_base_d;
    logic [IT_DEPTH-1:0] mask_q, mask_d;

    logic                w_go;
    logic                w_len_bad;
    logic                w_illegal;
    logic                w_pass;
    logic [3:0]          w_eff_cond;

    // Flags are {Z,C,N,V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, n, v;
        {z, cf, n, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf & !z;
            4'h9:    cond_pass = !cf | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_go       = valid_in & !stall & !flush;
        w_len_bad  = (it_len == '0) | (it_len > C_MAX_LEN);
        w_illegal  = it_start & (it_active_q | w_len_bad);
        w_eff_cond = it_active_q ? (it_base_q ^ {3'b000, mask_q[0]}) : cond;
        // A legal IT instruction itself always commits as a no-op
        w_pass     = (it_start & !it_active_q) ? 1'b1 : cond_pass(w_eff_cond, status_q);
        exec_en    = w_go & w_pass & !w_illegal;
    end

    always_comb begin
        status_d       = status_q;
        it_active_d    = it_active_q;
        it_remaining_d = it_remaining_q;
        it_base_d      = it_base_q;
        mask_d         = mask_q;
        it_err_d       = 1'b0;
        if (!stall) begin
            if (flush) begin
                it_active_d    = 1'b0;
                it_remaining_d = '0;
                it_base_d      = 4'h0;
                mask_d         = '0;
            end else if (valid_in) begin
                if (w_illegal) begin
                    it_err_d       = 1'b1;
                    it_active_d    = 1'b0;
                    it_remaining_d = '0;
                    it_base_d      = 4'h0;
                    mask_d         = '0;
                end else if (it_start) begin
                    it_active_d    = 1'b1;
                    it_remaining_d = it_len;
                    it_base_d      = it_cond;
                    mask_d         = it_mask;
                end else if (it_active_q) begin
                    it_remaining_d = it_remaining_q - 1'b1;
                    it_active_d    = (it_remaining_q != CNT_W'(1));
                    mask_d         = mask_q >> 1;
                end
                if (exec_en & s_update & !it_start) begin
                    status_d = alu_status;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q       <= STATUS_RST;
            it_active_q    <= 1'b0;
            it_remaining_q <= '0;
            it_err_q       <= 1'b0;
            it_base_q      <= 4'h0;
            mask_q         <= '0;
        end else begin
            status_q       <= status_d;
            it_active_q    <= it_active_d;
            it_remaining_q <= it_remaining_d;
            it_err_q       <= it_err_d;
            it_base_q      <= it_base_d;
            mask_q         <= mask_d;
        end
    end

    assign it_active    = it_active_q;
    assign it_remaining = it_remaining_q;
    assign it_err       = it_err_q;

endmodule
`default_nettype wire
